spi_stream_rx: RTL
==================

# spi_stream_rx

Parametrised serial-to-AXI4-Stream receiver. It oversamples the ASIC's serial link (sclk/sdata/svalid) in the aclk domain, deserialises MSB-first words of DATA_WIDTH bits, and buffers them in a FIFO of depth FIFO_DEPTH. Words are presented on an AXI4-Stream master with real backpressure, frame-based tlast, and short-word flagging. Overflow is accounted for rather than lost silently. It sits between the chip pads and the DMA/stream FIFO in the capture path.

## Interface
- DATA_WIDTH, 32: bits per word, 8..64.
- FIFO_DEPTH, 8: word buffer depth, power of 2, ≥2.
- FRAME_LEN, 4: words per frame; tlast is asserted on the last word of each frame, 1..255.
- SYNC_STAGES, 2: synchroniser flops on sclk/sdata/svalid, ≥2.

Ports:
- aclk  in  1  sole clock; all logic on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- sclk  in  1  serial clock, asynchronous to aclk; data is valid on its falling edge.
- sdata  in  1  serial data, MSB first.
- svalid  in  1  word-in-progress qualifier.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of frame.
- m_axis_tuser  out  1  1 = short (zero-padded) word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky flag, set on any dropped word.
- drop_count  out  16  dropped-word counter, saturates at 0xFFFF.
- clear_stats  in  1  synchronous clear of overflow and drop_count.

## Operation
- **Input sampling:** sclk, sdata and svalid each pass through SYNC_STAGES flops. A falling edge is detected when the previous synchronised sclk is 1 and the current one is 0. That detection cycle is the *sample cycle*, and sdata/svalid are taken from the same synchroniser stage.
- **Input clock constraint:** sclk high and low phases must each be ≥2 aclk periods. sdata and svalid must be stable around the sclk falling edge.
- **FSM states:**
  - IDLE: the shift register and bit count are 0. A sample with svalid=1 shifts in sdata (count=1) and moves to SHIFT. A sample with svalid=0 is ignored.
  - SHIFT: on each sample with svalid=1, sr <= {sr[W-2:0], sdata} and count++. When count reaches DATA_WIDTH, go to COMMIT with tuser=0. A sample with svalid=0 goes to COMMIT with tuser=1; the data is right-justified with the upper bits 0.
  - COMMIT: one cycle. Writes {tuser, tlast, sr} to the FIFO or drops it, clears sr and count, then returns to IDLE.
- **Sample during COMMIT:** cannot occur under the clock constraint above. If it does, the sample is ignored.
- **Frame counter (0..FRAME_LEN-1):**
  - Advances only on accepted words.
  - tlast=1 when the counter equals FRAME_LEN-1; the counter then wraps to 0.
  - A short word always carries tlast=1 and resets the counter to 0.
- **FIFO full:** fullness is evaluated with the same-cycle pop taken into account.
  - If full and there is no pop, the word is dropped. overflow is set, drop_count increments (saturating), and the frame counter is unchanged.
  - If full with a simultaneous pop, the word is accepted and fifo_level is unchanged.
- **Output:** first-word-fall-through. m_axis_tvalid = FIFO not empty, and tdata/tlast/tuser come from the head entry. A pop occurs when tvalid && tready. While tvalid=1 and tready=0, the outputs hold stable.
- **clear_stats:** overflow and drop_count are 0 on the next cycle. If a drop coincides with clear_stats, the clear wins and the count becomes 0.

## Timing
- **Reset values:** all outputs 0 (tvalid, tlast, tuser, tdata, fifo_level, overflow, drop_count). FSM in IDLE, FIFO empty, frame counter 0.
- **Reset mid-word:** the partial word and all FIFO contents are discarded. No output is produced until a new word completes after reset release.
- **Latency (empty FIFO):**
  - Edge-detect cycle N is the final sample of a word.
  - COMMIT occurs at N+1.
  - m_axis_tvalid=1 at N+2.
  - Pin-to-sample delay is SYNC_STAGES+1 aclk cycles.
- **Throughput:** one pop per aclk cycle when tready is held at 1.
- **fifo_level:** updates on the cycle after the push/pop. A simultaneous push and pop leaves it unchanged.

## Configuration
- **SPI_RX_PARITY_EN defined:**
  - Each word carries one extra trailing bit of odd parity over the data bits; a full word is DATA_WIDTH+1 samples.
  - A short word uses its last received bit as parity over the preceding bits.
  - A mismatch drops the word without a FIFO write or frame-counter change.
  - A parity error sets the additional output port parity_err (1 bit, sticky, cleared by clear_stats, reset 0).
- **Undefined:** no parity bit, no parity_err port. Words are exactly DATA_WIDTH samples.

## Test plan
- DATA_WIDTH=32, send 0xDEADBEEF with tready=1 → tdata=0xDEADBEEF, tuser=0, tlast=0, and tvalid rises exactly 2 cycles after the final edge-detect.
- Send 8 full words with FRAME_LEN=4 → tlast=1 on words 4 and 8 only.
- Send 12 bits 0xABC, then drop svalid → tdata=0x00000ABC, tuser=1, tlast=1, and the next word starts a new frame.
- With tready=0 and FIFO_DEPTH=8, send 10 words → fifo_level=8, drop_count=2, overflow=1. Then raise tready → the 8 earliest words drain in order. Pulse clear_stats → drop_count=0 and overflow=0.
- Assert aresetn=0 after 16 of 32 bits → all outputs 0. After release, a fresh 0x12345678 is received intact.
- With SPI_RX_PARITY_EN, send 0x00000001 with parity 1 → word dropped, parity_err=1. Then send it with parity 0 → word accepted.

Source files
------------

// File: rtl/spi_stream_rx.sv
// Purpose : oversampled serial (sclk/sdata/svalid) to AXI4-Stream word receiver with FIFO, frame tlast and drop stats.
// Latency : final sample cycle N -> commit at N+1 -> m_axis_tvalid at N+2 (empty FIFO), after SYNC_STAGES of pin sync.
// Backpr. : m_axis_tready stalls the FWFT FIFO; a word committing into a full FIFO with no pop is dropped and counted.
//
// Ports   : aclk/aresetn (async active-low); sclk/sdata/svalid serial link (async to aclk);
//           m_axis_* stream master (tuser=1 marks a short, zero-padded word); fifo_level occupancy;
//           overflow/drop_count sticky drop stats, cleared by clear_stats.
// Option  : define SPI_RX_PARITY_EN to expect a trailing odd-parity bit per word and add the parity_err output.
module spi_stream_rx #(
   parameter int DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 8,
   parameter int FRAME_LEN   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          sclk,
   input  logic                          sdata,
   input  logic                          svalid,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [15:0]                   drop_count,
   input  logic                          clear_stats
`ifdef SPI_RX_PARITY_EN
   ,
   output logic                          parity_err
`endif
);

`ifdef SPI_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // The shift register also holds the parity bit (when present) in its LSB.
   localparam int SR_W  = DATA_WIDTH + PAR_BITS;
   localparam int CNT_W = $clog2(SR_W + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

   typedef struct packed {
      logic                  tuser;
      logic                  tlast;
      logic [DATA_WIDTH-1:0] dat;
   } entry_t;

   // ---------------- input synchronisers and falling-edge detect ----------------
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
   logic [SYNC_STAGES-1:0] svalid_sync_q, svalid_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   sclk_s, sdata_s, svalid_s, sample;

   always_comb begin
      sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sdata_sync_d  = {sdata_sync_q[SYNC_STAGES-2:0], sdata};
      svalid_sync_d = {svalid_sync_q[SYNC_STAGES-2:0], svalid};
      sclk_s        = sclk_sync_q[SYNC_STAGES-1];
      sdata_s       = sdata_sync_q[SYNC_STAGES-1];
      svalid_s      = svalid_sync_q[SYNC_STAGES-1];
      sclk_prev_d   = sclk_s;
      sample        = sclk_prev_q & ~sclk_s;
   end

   // ---------------- deserialiser FSM ----------------
   state_t            state_q, state_d;
   logic [SR_W-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              short_q, short_d;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      short_d = short_q;
      case (state_q)
         ST_IDLE: begin
            if (sample && svalid_s) begin
               sr_d    = {{(SR_W-1){1'b0}}, sdata_s};
               cnt_d   = CNT_W'(1);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sample) begin
               if (svalid_s) begin
                  sr_d  = {sr_q[SR_W-2:0], sdata_s};
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(SR_W - 1)) begin
                     short_d = 1'b0;
                     state_d = ST_COMMIT;
                  end
               end else begin
                  // Early svalid drop: the bits already shifted in are right-justified.
                  short_d = 1'b1;
                  state_d = ST_COMMIT;
               end
            end
         end
         ST_COMMIT: begin
            // Any sample landing here is ignored; the link timing keeps it from happening.
            sr_d    = '0;
            cnt_d   = '0;
            short_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            sr_d    = '0;
            cnt_d   = '0;
            short_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------- commit / FIFO control ----------------
   entry_t            mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [7:0]        frame_q, frame_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic              commit, par_ok, pop, push, drop, full_no_pop, word_last;
   entry_t            wr_entry;
`ifdef SPI_RX_PARITY_EN
   logic              parity_err_q, parity_err_d;
`endif

   always_comb begin
      commit = (state_q == ST_COMMIT);
`ifdef SPI_RX_PARITY_EN
      // Odd parity: data bits plus the parity bit must hold an odd number of ones.
      par_ok = ^sr_q;
`else
      par_ok = 1'b1;
`endif
      pop         = (level_q != '0) && m_axis_tready;
      // A pop in the same cycle frees the slot the commit needs.
      full_no_pop = (level_q == LVL_W'(FIFO_DEPTH)) && !pop;
      push        = commit && par_ok && !full_no_pop;
      drop        = commit && par_ok && full_no_pop;
      word_last   = short_q || (frame_q == 8'(FRAME_LEN - 1));

      wr_entry.tuser = short_q;
      wr_entry.tlast = word_last;
      wr_entry.dat   = sr_q[SR_W-1:PAR_BITS];

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

      frame_d = frame_q;
      if (push) frame_d = word_last ? 8'd0 : frame_q + 8'd1;

      overflow_d = overflow_q | drop;
      drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
      if (clear_stats) begin
         overflow_d = 1'b0;
         drop_cnt_d = 16'd0;
      end
`ifdef SPI_RX_PARITY_EN
      parity_err_d = clear_stats ? 1'b0 : (parity_err_q | (commit && !par_ok));
`endif
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sclk_sync_q   <= '0;
         sdata_sync_q  <= '0;
         svalid_sync_q <= '0;
         sclk_prev_q   <= 1'b0;
         state_q       <= ST_IDLE;
         sr_q          <= '0;
         cnt_q         <= '0;
         short_q       <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         frame_q       <= 8'd0;
         overflow_q    <= 1'b0;
         drop_cnt_q    <= 16'd0;
`ifdef SPI_RX_PARITY_EN
         parity_err_q  <= 1'b0;
`endif
      end else begin
         sclk_sync_q   <= sclk_sync_d;
         sdata_sync_q  <= sdata_sync_d;
         svalid_sync_q <= svalid_sync_d;
         sclk_prev_q   <= sclk_prev_d;
         state_q       <= state_d;
         sr_q          <= sr_d;
         cnt_q         <= cnt_d;
         short_q       <= short_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         frame_q       <= frame_d;
         overflow_q    <= overflow_d;
         drop_cnt_q    <= drop_cnt_d;
`ifdef SPI_RX_PARITY_EN
         parity_err_q  <= parity_err_d;
`endif
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   // ---------------- outputs ----------------
   always_comb begin
      m_axis_tvalid = (level_q != '0);
      m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q].dat   : '0;
      m_axis_tlast  = m_axis_tvalid ? mem_q[rd_ptr_q].tlast : 1'b0;
      m_axis_tuser  = m_axis_tvalid ? mem_q[rd_ptr_q].tuser : 1'b0;
      fifo_level    = level_q;
      overflow      = overflow_q;
      drop_count    = drop_cnt_q;
`ifdef SPI_RX_PARITY_EN
      parity_err    = parity_err_q;
`endif
   end

endmodule
